// File: rtl/code_checker.sv
// Password datapath beside the lock FSM: captures keypad digits on FSM strobes,
// holds the stored code and returns a single result pulse when compare is released.
module code_checker #(
   parameter int                          DIGIT_W      = 4,
   parameter int                          CODE_LEN     = 4,
   parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
   input  logic               clk,
   input  logic               system_reset,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               input_value,
   input  logic               store_value,
   input  logic               compare,
   output logic               correct_password,
   output logic               invalid_password,
   output logic               store_done,
   output logic [2:0]         entry_count
);

   localparam int         CODE_W = DIGIT_W * CODE_LEN;
   localparam logic [2:0] LEN    = 3'(CODE_LEN);

   logic              in_d;
   logic              st_d;
   logic              cmp_d;
   logic [CODE_W-1:0] entry;
   logic [CODE_W-1:0] staging;
   logic [CODE_W-1:0] stored;
   logic [2:0]        stage_count;
   logic              entry_ovf;

   logic              in_rise;
   logic              st_rise;
   logic              cmp_fall;
   logic              match;
   logic              stage_last;
   logic [2:0]        stage_inc;
   logic [CODE_W-1:0] entry_shift;
   logic [CODE_W-1:0] staging_shift;

   // Edge events, shifted registers and the match decision from pre-edge state
   always_comb begin
      in_rise       = input_value & ~in_d;
      st_rise       = store_value & ~st_d;
      cmp_fall      = ~compare & cmp_d;
      entry_shift   = CODE_W'({entry, digit_in});
      staging_shift = CODE_W'({staging, digit_in});
      stage_inc     = stage_count + 3'd1;
      stage_last    = (stage_inc == LEN);
      match         = (entry_count == LEN) & ~entry_ovf & (entry == stored);
   end

   // State update; compare release outranks entry capture, which outranks store capture
   always_ff @(posedge clk) begin
      if (system_reset) begin
         in_d             <= 1'b0;
         st_d             <= 1'b0;
         cmp_d            <= 1'b0;
         entry            <= '0;
         staging          <= '0;
         stored           <= DEFAULT_CODE;
         entry_count      <= 3'd0;
         stage_count      <= 3'd0;
         entry_ovf        <= 1'b0;
         correct_password <= 1'b0;
         invalid_password <= 1'b0;
         store_done       <= 1'b0;
      end else begin
         in_d             <= input_value;
         st_d             <= store_value;
         cmp_d            <= compare;
         correct_password <= cmp_fall & match;
         invalid_password <= cmp_fall & ~match;
         store_done       <= 1'b0;
         if (cmp_fall) begin
            entry       <= '0;
            entry_count <= 3'd0;
            entry_ovf   <= 1'b0;
            staging     <= '0;
            stage_count <= 3'd0;
         end else if (in_rise) begin
            entry <= entry_shift;
            if (entry_count < LEN) begin
               entry_count <= entry_count + 3'd1;
            end else begin
               entry_ovf <= 1'b1;
            end
         end else if (st_rise) begin
            staging <= staging_shift;
            if (stage_last) begin
               stored      <= staging_shift;
               stage_count <= 3'd0;
               store_done  <= 1'b1;
            end else begin
               stage_count <= stage_inc;
            end
         end else begin
            entry <= entry;
         end
      end
   end

endmodule

// File: tb/tb_code_checker.sv
// Directed self-checking bench for code_checker with the default 4x4-bit code 0x1234.
module tb_code_checker;

   logic       clk;
   logic       system_reset;
   logic [3:0] digit_in;
   logic       input_value;
   logic       store_value;
   logic       compare;
   logic       correct_password;
   logic       invalid_password;
   logic       store_done;
   logic [2:0] entry_count;

   int n_checks;
   int n_fail;

   logic       c_b, i_b, c_a, i_a, c_f, i_f;
   logic [2:0] cnt_a;
   logic [2:0] kc;
   logic       sd_a, sd_b;

   code_checker dut (
      .clk              (clk),
      .system_reset     (system_reset),
      .digit_in         (digit_in),
      .input_value      (input_value),
      .store_value      (store_value),
      .compare          (compare),
      .correct_password (correct_password),
      .invalid_password (invalid_password),
      .store_done       (store_done),
      .entry_count      (entry_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      system_reset = 1'b1;
      input_value  = 1'b0;
      store_value  = 1'b0;
      compare      = 1'b0;
      digit_in     = 4'd0;
      step();
      step();
      system_reset = 1'b0;
   endtask

   // One keyed entry digit: high one cycle, low one cycle; returns count after capture
   task automatic key_digit(input logic [3:0] d, output logic [2:0] cnt);
      digit_in    = d;
      input_value = 1'b1;
      step();
      cnt         = entry_count;
      input_value = 1'b0;
      step();
   endtask

   task automatic store_digit(input logic [3:0] d);
      digit_in    = d;
      store_value = 1'b1;
      step();
      sd_a        = store_done;
      store_value = 1'b0;
      step();
      sd_b        = store_done;
   endtask

   // Press and release compare; record outputs before, at and after the result cycle
   task automatic submit();
      compare = 1'b1;
      step();
      compare = 1'b0;
      c_b = correct_password;
      i_b = invalid_password;
      step();
      c_a   = correct_password;
      i_a   = invalid_password;
      cnt_a = entry_count;
      step();
      c_f = correct_password;
      i_f = invalid_password;
   endtask

   task automatic key_code(input logic [15:0] code);
      for (int k = 3; k >= 0; k--) begin
         key_digit(code[k*4 +: 4], kc);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({correct_password, invalid_password, store_done, entry_count} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {correct_password, invalid_password, store_done, entry_count});
      end
   endtask

   task automatic test_correct();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         key_digit(4'(k), kc);
         n_checks++;
         if (kc !== 3'(k)) begin
            n_fail++;
            $display("FAIL correct_count%0d: got %0d expected %0d", k, kc, k);
         end
      end
      submit();
      n_checks++;
      if ({c_b, c_a, i_a, c_f} !== 4'b0100) begin
         n_fail++;
         $display("FAIL correct_pulse: got before/at/inv/after %b expected 0100", {c_b, c_a, i_a, c_f});
      end
      n_checks++;
      if (cnt_a !== 3'd0) begin
         n_fail++;
         $display("FAIL correct_clear: got %0d expected 0", cnt_a);
      end
   endtask

   task automatic test_invalid();
      do_reset();
      key_code(16'h1235);
      submit();
      n_checks++;
      if ({i_b, i_a, c_a, i_f} !== 4'b0100) begin
         n_fail++;
         $display("FAIL invalid_wrong: got before/at/corr/after %b expected 0100", {i_b, i_a, c_a, i_f});
      end
      key_digit(4'd1, kc);
      key_digit(4'd2, kc);
      key_digit(4'd3, kc);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b10) begin
         n_fail++;
         $display("FAIL invalid_short: got inv/corr %b expected 10", {i_a, c_a});
      end
      key_code(16'h1234);
      key_digit(4'd4, kc);
      n_checks++;
      if (kc !== 3'd4) begin
         n_fail++;
         $display("FAIL invalid_saturate: got %0d expected 4", kc);
      end
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b10) begin
         n_fail++;
         $display("FAIL invalid_overflow: got inv/corr %b expected 10", {i_a, c_a});
      end
   endtask

   task automatic test_store();
      do_reset();
      store_digit(4'd9);
      store_digit(4'd8);
      store_digit(4'd7);
      n_checks++;
      if (sd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL store_early: got %b expected 0", sd_a);
      end
      store_digit(4'd6);
      n_checks++;
      if ({sd_a, sd_b} !== 2'b10) begin
         n_fail++;
         $display("FAIL store_done: got %b expected 10", {sd_a, sd_b});
      end
      key_code(16'h1234);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b10) begin
         n_fail++;
         $display("FAIL store_old_code: got inv/corr %b expected 10", {i_a, c_a});
      end
      key_code(16'h9876);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL store_new_code: got inv/corr %b expected 01", {i_a, c_a});
      end
   endtask

   task automatic test_partial_store();
      do_reset();
      store_digit(4'd5);
      store_digit(4'd5);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b10) begin
         n_fail++;
         $display("FAIL partial_empty: got inv/corr %b expected 10", {i_a, c_a});
      end
      key_code(16'h1234);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL partial_kept: got inv/corr %b expected 01", {i_a, c_a});
      end
      store_digit(4'd4);
      store_digit(4'd3);
      n_checks++;
      if (sd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL partial_discard: got %b expected 0", sd_a);
      end
      store_digit(4'd2);
      store_digit(4'd1);
      n_checks++;
      if (sd_a !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_commit: got %b expected 1", sd_a);
      end
      key_code(16'h4321);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL partial_new_code: got inv/corr %b expected 01", {i_a, c_a});
      end
   endtask

   task automatic test_hold();
      do_reset();
      digit_in    = 4'd1;
      input_value = 1'b1;
      repeat (10) step();
      n_checks++;
      if (entry_count !== 3'd1) begin
         n_fail++;
         $display("FAIL hold_single: got %0d expected 1", entry_count);
      end
      input_value = 1'b0;
      step();
      key_digit(4'd2, kc);
      key_digit(4'd3, kc);
      key_digit(4'd4, kc);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_code: got inv/corr %b expected 01", {i_a, c_a});
      end
   endtask

   task automatic test_coincide();
      do_reset();
      key_code(16'h1234);
      compare = 1'b1;
      step();
      compare     = 1'b0;
      digit_in    = 4'd5;
      input_value = 1'b1;
      step();
      n_checks++;
      if ({correct_password, invalid_password, entry_count} !== 5'b10000) begin
         n_fail++;
         $display("FAIL cmp_vs_in: got corr/inv/count %b expected 10000",
                  {correct_password, invalid_password, entry_count});
      end
      input_value = 1'b0;
      step();
      n_checks++;
      if ({correct_password, entry_count} !== 4'b0000) begin
         n_fail++;
         $display("FAIL cmp_vs_in_after: got corr/count %b expected 0000", {correct_password, entry_count});
      end
      digit_in    = 4'd9;
      input_value = 1'b1;
      store_value = 1'b1;
      step();
      n_checks++;
      if (entry_count !== 3'd1) begin
         n_fail++;
         $display("FAIL in_vs_st_count: got %0d expected 1", entry_count);
      end
      input_value = 1'b0;
      store_value = 1'b0;
      step();
      submit();
      store_digit(4'd8);
      store_digit(4'd7);
      store_digit(4'd6);
      n_checks++;
      if (sd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL in_vs_st_drop: got %b expected 0", sd_a);
      end
      store_digit(4'd5);
      key_code(16'h8765);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL in_vs_st_code: got inv/corr %b expected 01", {i_a, c_a});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      key_digit(4'd1, kc);
      key_digit(4'd2, kc);
      system_reset = 1'b1;
      step();
      n_checks++;
      if ({correct_password, invalid_password, store_done, entry_count} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b expected 000000",
                  {correct_password, invalid_password, store_done, entry_count});
      end
      system_reset = 1'b0;
      key_code(16'h1234);
      submit();
      n_checks++;
      if ({i_a, c_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_mid_code: got inv/corr %b expected 01", {i_a, c_a});
      end
      key_code(16'h1234);
      compare = 1'b1;
      step();
      compare      = 1'b0;
      system_reset = 1'b1;
      step();
      system_reset = 1'b0;
      step();
      n_checks++;
      if ({correct_password, invalid_password} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_pending: got corr/inv %b expected 00", {correct_password, invalid_password});
      end
      system_reset = 1'b1;
      digit_in     = 4'd7;
      input_value  = 1'b1;
      step();
      system_reset = 1'b0;
      step();
      n_checks++;
      if (entry_count !== 3'd1) begin
         n_fail++;
         $display("FAIL reset_high_rise: got %0d expected 1", entry_count);
      end
      input_value = 1'b0;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_correct();
      test_invalid();
      test_store();
      test_partial_store();
      test_hold();
      test_coincide();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
